ctrl_seq: RTL

- Parametrised, multi-cycle successor to the combinational control decoder.
- Decodes each instruction into an instruction class, then sequences it.
  - ALU/branch/store instructions take one cycle.
  - Loads take a parametrised memory latency before write-back.
  - The done instruction ends the program with a held Ack and a Start/Ack handshake.
- Sits between instruction ROM and fetch unit / reg_file / data memory.
- Owns the PC advance enable and a retired-instruction counter.

---
 rtl/ctrl_seq_pkg.sv | 25 ++
 rtl/ctrl_decode.sv | 32 +++
 rtl/ctrl_seq.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/ctrl_seq_pkg.sv
// Shared types and opcode constants for the control sequencer and its decoder.
package ctrl_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        LDWAIT,
        DONE
    } ctrl_state_t;

    typedef enum logic [2:0] {
        C_ALU,
        C_ALUI,
        C_STR,
        C_LOD,
        C_BR,
        C_DONE
    } instr_class_t;

    localparam logic [3:0] kSTR = 4'd1;
    localparam logic [3:0] kLOD = 4'd2;
    localparam logic [3:0] kBNE = 4'd3;
    localparam logic [3:0] kBGT = 4'd4;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational instruction classifier; zero latency, no flow control.
module ctrl_decode
    import ctrl_seq_pkg::*;
#(
    parameter int INSTR_W = 9,
    parameter int OPC_W   = 4
) (
    input  logic [INSTR_W-1:0] instr,
    output instr_class_t       cls
);

    logic [OPC_W-1:0] opc;

    assign opc = instr[INSTR_W-2 -: OPC_W];

    // The all-ones done word also has MSB set, so it must win over ALUI.
    always_comb begin
        cls = C_ALU;
        if (&instr) begin
            cls = C_DONE;
        end else if (instr[INSTR_W-1]) begin
            cls = C_ALUI;
        end else if (opc == OPC_W'(kSTR)) begin
            cls = C_STR;
        end else if (opc == OPC_W'(kLOD)) begin
            cls = C_LOD;
        end else if (opc == OPC_W'(kBNE) || opc == OPC_W'(kBGT)) begin
            cls = C_BR;
        end
    end

endmodule

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer: 1-cycle ALU/branch/store, LOAD_LAT+1-cycle loads.
// Stall freezes state and drops all enables while busy; Start/Ack handshake ends a program.
module ctrl_seq
    import ctrl_seq_pkg::*;
#(
    parameter int INSTR_W  = 9,
    parameter int OPC_W    = 4,
    parameter int LOAD_LAT = 2,
    parameter int CNT_W    = 16
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Start,
    input  logic [INSTR_W-1:0] Instruction,
    input  logic               Stall,
    output logic               PcEn,
    output logic               BranchEn,
    output logic               RegWrEn,
    output logic               MemWrEn,
    output logic               MemRdEn,
    output logic               LoadInst,
    output logic               Busy,
    output logic               Ack,
    output logic [CNT_W-1:0]   RetireCnt
);

    localparam int WCW = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;

    ctrl_state_t    state, state_nxt;
    instr_class_t   cls;
    logic [WCW-1:0] wait_cnt, wait_nxt;
    logic [CNT_W-1:0] retire_cnt, retire_nxt, retire_inc;

    logic pc_en, br_en, reg_wr, mem_wr, mem_rd, load_sel, busy, ack;

    ctrl_decode #(
        .INSTR_W (INSTR_W),
        .OPC_W   (OPC_W)
    ) u_decode (
        .instr (Instruction),
        .cls   (cls)
    );

    assign retire_inc = (&retire_cnt) ? retire_cnt : retire_cnt + CNT_W'(1);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            retire_cnt <= '0;
        end else begin
            state      <= state_nxt;
            wait_cnt   <= wait_nxt;
            retire_cnt <= retire_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        wait_nxt   = wait_cnt;
        retire_nxt = retire_cnt;
        pc_en      = 1'b0;
        br_en      = 1'b0;
        reg_wr     = 1'b0;
        mem_wr     = 1'b0;
        mem_rd     = 1'b0;
        load_sel   = 1'b0;
        busy       = 1'b0;
        ack        = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    state_nxt  = EXEC;
                    retire_nxt = '0;
                end
            end
            EXEC: begin
                busy = 1'b1;
                if (!Stall) begin
                    case (cls)
                        C_ALU, C_ALUI: begin
                            reg_wr     = 1'b1;
                            pc_en      = 1'b1;
                            retire_nxt = retire_inc;
                        end
                        C_STR: begin
                            mem_wr     = 1'b1;
                            pc_en      = 1'b1;
                            retire_nxt = retire_inc;
                        end
                        C_BR: begin
                            br_en      = 1'b1;
                            pc_en      = 1'b1;
                            retire_nxt = retire_inc;
                        end
                        C_LOD: begin
                            mem_rd    = 1'b1;
                            wait_nxt  = WCW'(LOAD_LAT - 1);
                            state_nxt = LDWAIT;
                        end
                        C_DONE: begin
                            retire_nxt = retire_inc;
                            state_nxt  = DONE;
                        end
                        default: ;
                    endcase
                end
            end
            LDWAIT: begin
                busy = 1'b1;
                // PC is frozen here, so the load is completed without re-decoding.
                if (!Stall) begin
                    if (wait_cnt != '0) begin
                        wait_nxt = wait_cnt - WCW'(1);
                    end else begin
                        reg_wr     = 1'b1;
                        load_sel   = 1'b1;
                        pc_en      = 1'b1;
                        retire_nxt = retire_inc;
                        state_nxt  = EXEC;
                    end
                end
            end
            DONE: begin
                ack = 1'b1;
                if (Start) begin
                    state_nxt  = EXEC;
                    retire_nxt = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are forced low for as long as reset is asserted, not just after the edge.
    assign PcEn      = Reset & pc_en;
    assign BranchEn  = Reset & br_en;
    assign RegWrEn   = Reset & reg_wr;
    assign MemWrEn   = Reset & mem_wr;
    assign MemRdEn   = Reset & mem_rd;
    assign LoadInst  = Reset & load_sel;
    assign Busy      = Reset & busy;
    assign Ack       = Reset & ack;
    assign RetireCnt = Reset ? retire_cnt : '0;

    a_one_writer: assert property (@(posedge Clk) $onehot0({RegWrEn, MemWrEn, BranchEn}));

endmodule
